secded_encoder_tx: RTL and testbench

- Upstream stage of the 13-bit SECDED decoder: accepts 8-bit data words over a valid/ready handshake and encodes each into a 13-bit Hamming+overall-parity codeword.
- Optionally XORs a programmable error mask into the codeword so the decoder's 1-bit and 2-bit error paths can be exercised.
- Buffers codewords in a small FIFO and presents them to the decoder over a valid/ready handshake.
- Keeps sent-word and injected-error counters for display.

---
 rtl/secded_encoder_tx_pkg.sv | 16 +
 rtl/secded_encoder_tx_if.sv | 22 ++
 rtl/secded_encoder_tx_encode.sv | 32 +++
 rtl/secded_encoder_tx.sv | 92 +++++++++
 tb/tb_secded_encoder_tx.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/secded_encoder_tx_pkg.sv
// Shared SECDED(13,8) codeword layout, used by both the encoder and the decoder
// so the two sides always agree on where parity and data bits live.
package secded_pkg;

  localparam int DATA_W = 8;
  localparam int CODE_W = 13;
  localparam int SYN_W  = 4;

  typedef logic [CODE_W-1:0] codeword_t;

  // Hamming positions (code bit index) of the parity bits and of data bits d[0..7]
  localparam logic [3:0] PARITY_POS [SYN_W]  = '{4'd1, 4'd2, 4'd4, 4'd8};
  localparam logic [3:0] DATA_POS   [DATA_W] = '{4'd3, 4'd5, 4'd6, 4'd7,
                                                 4'd9, 4'd10, 4'd11, 4'd12};

endpackage

// File: rtl/secded_encoder_tx_if.sv
// Data-in and codeword-out valid/ready bus between the producer, the encoder and the decoder.
// The slave modport is the encoder's view; master is the surrounding logic's view.
interface secded_encoder_tx_if;
  import secded_pkg::*;

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  codeword_t         out_code;
  logic              out_valid;
  logic              out_ready;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_code, out_valid
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_code, out_valid
  );
endinterface

// File: rtl/secded_encoder_tx_encode.sv
// Combinational 8-bit -> 13-bit Hamming encoder with overall even parity in bit 0.
// Zero latency, no flow control.
module secded_encode
  import secded_pkg::*;
(
  input  logic [DATA_W-1:0] i_data,
  output codeword_t         o_code
);

  codeword_t w_code;
  logic      w_par;

  always_comb begin
    w_code = '0;
    w_par  = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      w_code[DATA_POS[i]] = i_data[i];
    end
    // Parity slots are still zero when each p_k is computed, so including them is harmless
    for (int k = 0; k < SYN_W; k++) begin
      w_par = 1'b0;
      for (int j = 1; j < CODE_W; j++) begin
        if (j[k]) w_par = w_par ^ w_code[j[3:0]];
      end
      w_code[PARITY_POS[k]] = w_par;
    end
    w_code[0] = ^w_code[CODE_W-1:1];
  end

  assign o_code = w_code;

endmodule

// File: rtl/secded_encoder_tx.sv
// Encodes accepted bytes to SECDED codewords, optionally corrupts them, and queues them for the decoder.
// Accept-to-out_valid latency is 1 cycle; in_ready drops when the FIFO is full (no write-through).
module secded_encoder_tx
  import secded_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic                clock,
  input  logic                reset_L,
  secded_encoder_tx_if.slave  bus,
  input  codeword_t           inj_mask,
  input  logic                inj_always,
  input  logic                inj_arm,
  output logic [CNT_W-1:0]    words_sent,
  output logic [7:0]          errs_injected,
  output logic                armed
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_FW = $clog2(DEPTH + 1);

  codeword_t          r_mem [DEPTH];
  logic               r_tag [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_FW-1:0]  r_count;
  logic               r_live;
  logic               r_armed;
  logic [CNT_W-1:0]   r_words;
  logic [7:0]         r_errs;

  codeword_t w_code;
  codeword_t w_mask;
  logic      w_push;
  logic      w_pop;

  secded_encode u_encode (
    .i_data (bus.in_data),
    .o_code (w_code)
  );

  // r_live holds in_ready low until the first edge after reset release
  assign bus.in_ready  = r_live && (r_count < CNT_FW'(DEPTH));
  assign bus.out_valid = (r_count != '0);
  assign bus.out_code  = r_mem[r_rd_ptr];

  assign w_push = bus.in_valid && bus.in_ready;
  assign w_pop  = bus.out_valid && bus.out_ready;
  assign w_mask = (inj_always || r_armed) ? inj_mask : '0;

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
        r_tag[i] <= 1'b0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_live   <= 1'b0;
      r_armed  <= 1'b0;
      r_words  <= '0;
      r_errs   <= '0;
    end else begin
      r_live <= 1'b1;
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_code ^ w_mask;
        r_tag[r_wr_ptr] <= |w_mask;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        r_words  <= r_words + CNT_W'(1);
        if (r_tag[r_rd_ptr] && (r_errs != 8'hFF)) r_errs <= r_errs + 8'd1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_FW'(1);
        2'b01:   r_count <= r_count - CNT_FW'(1);
        default: r_count <= r_count;
      endcase
      // A new arm always wins: a coincident accept either consumes the old arm or precedes the new one
      if (inj_arm)     r_armed <= 1'b1;
      else if (w_push) r_armed <= 1'b0;
    end
  end

  assign words_sent    = r_words;
  assign errs_injected = r_errs;
  assign armed         = r_armed;

endmodule

// File: tb/tb_secded_encoder_tx.sv
// Directed checks of encoding, error injection, arming, backpressure, saturation and async reset.
module tb_secded_encoder_tx;
  import secded_pkg::*;

  logic        clock;
  logic        reset_L;
  codeword_t   inj_mask;
  logic        inj_always;
  logic        inj_arm;
  logic [15:0] words_sent;
  logic [7:0]  errs_injected;
  logic        armed;

  int n_chk = 0;
  int n_err = 0;

  secded_encoder_tx_if bus ();

  secded_encoder_tx #(.DEPTH(2), .CNT_W(16)) dut (
    .clock         (clock),
    .reset_L       (reset_L),
    .bus           (bus),
    .inj_mask      (inj_mask),
    .inj_always    (inj_always),
    .inj_arm       (inj_arm),
    .words_sent    (words_sent),
    .errs_injected (errs_injected),
    .armed         (armed)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Returns one tick after the accepting edge, with in_valid dropped
  task automatic push_word(input logic [7:0] d);
    int g;
    g = 0;
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && g < 20) begin
      step();
      g++;
    end
    chk("push_ready", {31'd0, bus.in_ready}, 32'd1);
    step();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    int n;
    int guard;
    reset_L       = 1'b0;
    bus.in_data   = 8'h00;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    inj_mask      = '0;
    inj_always    = 1'b0;
    inj_arm       = 1'b0;

    #12;
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("rst_out_code", {19'd0, bus.out_code}, 32'h0);
    chk("rst_words", {16'd0, words_sent}, 32'd0);
    chk("rst_errs", {24'd0, errs_injected}, 32'd0);
    chk("rst_armed", {31'd0, armed}, 32'd0);
    @(posedge clock);
    #1;
    reset_L = 1'b1;
    chk("rel_in_ready_pre", {31'd0, bus.in_ready}, 32'd0);
    step();
    chk("rel_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // Zero word, 1-cycle latency
    push_word(8'h00);
    chk("d00_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("d00_code", {19'd0, bus.out_code}, 32'h0000);
    step();
    chk("d00_words", {16'd0, words_sent}, 32'd1);
    chk("d00_drained", {31'd0, bus.out_valid}, 32'd0);

    // Back-to-back clean words
    push_word(8'hFF);
    chk("dFF_code", {19'd0, bus.out_code}, 32'h1EEE);
    push_word(8'h01);
    chk("d01_code", {19'd0, bus.out_code}, 32'h000F);
    step();
    chk("clean_words", {16'd0, words_sent}, 32'd3);
    chk("clean_errs", {24'd0, errs_injected}, 32'd0);

    // One-shot single-bit injection
    inj_mask = 13'h0010;
    inj_arm  = 1'b1;
    step();
    inj_arm = 1'b0;
    chk("arm_set", {31'd0, armed}, 32'd1);
    push_word(8'hFF);
    chk("arm_code", {19'd0, bus.out_code}, 32'h1EFE);
    chk("arm_cleared", {31'd0, armed}, 32'd0);
    push_word(8'hFF);
    chk("post_arm_code", {19'd0, bus.out_code}, 32'h1EEE);
    step();
    chk("arm_errs", {24'd0, errs_injected}, 32'd1);
    chk("arm_words", {16'd0, words_sent}, 32'd5);

    // Continuous double-bit injection and saturation
    inj_always = 1'b1;
    inj_mask   = 13'h0003;
    push_word(8'h00);
    chk("always_code", {19'd0, bus.out_code}, 32'h0003);
    step();
    chk("always_errs", {24'd0, errs_injected}, 32'd2);
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b1;
    n = 0;
    guard = 0;
    while (n < 300 && guard < 1000) begin
      if (bus.in_ready) n++;
      step();
      guard++;
    end
    bus.in_valid = 1'b0;
    chk("stream_accepts", n, 300);
    step();
    step();
    chk("sat_errs", {24'd0, errs_injected}, 32'd255);
    chk("sat_words", {16'd0, words_sent}, 32'd306);

    // Arm coinciding with an accept while unarmed: this word clean, next word injected
    inj_always = 1'b0;
    inj_mask   = 13'h0010;
    inj_arm    = 1'b1;
    push_word(8'h01);
    inj_arm = 1'b0;
    chk("coarm_code", {19'd0, bus.out_code}, 32'h000F);
    chk("coarm_armed", {31'd0, armed}, 32'd1);
    push_word(8'h01);
    chk("coarm_next_code", {19'd0, bus.out_code}, 32'h001F);
    chk("coarm_consumed", {31'd0, armed}, 32'd0);
    step();
    chk("coarm_words", {16'd0, words_sent}, 32'd308);
    chk("sat_hold_errs", {24'd0, errs_injected}, 32'd255);

    // Backpressure: DEPTH words fill the FIFO, head stays put
    inj_mask      = '0;
    bus.out_ready = 1'b0;
    push_word(8'hA5);
    chk("bp_first_code", {19'd0, bus.out_code}, 32'h144E);
    push_word(8'h3C);
    chk("bp_full_ready", {31'd0, bus.in_ready}, 32'd0);
    bus.in_data  = 8'h0F;
    bus.in_valid = 1'b1;
    step();
    step();
    step();
    chk("bp_hold_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("bp_hold_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("bp_hold_code", {19'd0, bus.out_code}, 32'h144E);
    bus.out_ready = 1'b1;
    step();
    chk("bp_second_code", {19'd0, bus.out_code}, 32'h06C5);
    step();
    chk("bp_third_code", {19'd0, bus.out_code}, 32'h00FF);
    bus.in_valid = 1'b0;
    step();
    chk("bp_drained", {31'd0, bus.out_valid}, 32'd0);
    chk("bp_words", {16'd0, words_sent}, 32'd311);

    // Asynchronous reset with a full FIFO and a pending arm
    bus.out_ready = 1'b0;
    push_word(8'h11);
    push_word(8'h22);
    inj_arm = 1'b1;
    step();
    inj_arm = 1'b0;
    chk("pre_rst_armed", {31'd0, armed}, 32'd1);
    chk("pre_rst_full", {31'd0, bus.in_ready}, 32'd0);
    #2;
    reset_L = 1'b0;
    #1;
    chk("arst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("arst_words", {16'd0, words_sent}, 32'd0);
    chk("arst_errs", {24'd0, errs_injected}, 32'd0);
    chk("arst_armed", {31'd0, armed}, 32'd0);
    chk("arst_code", {19'd0, bus.out_code}, 32'h0);
    @(posedge clock);
    #1;
    reset_L = 1'b1;
    bus.out_ready = 1'b1;
    step();
    chk("post_rst_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("post_rst_empty", {31'd0, bus.out_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
